// File: rtl/rv32_ahb_sram_slave.sv
// rv32_ahb_sram_slave
// AHB-Lite slave in front of the unified single-port on-chip SRAM macro.
// Address-phase reads are issued straight to the macro. Writes are committed
// in their data phase. A read that arrives while a write owns the macro port
// is deferred by one wait state.
//
// Optional feature macro: RV32_SRAM_ERRCHK_EN
//   defined   - range, alignment and HSIZE checks; bad transfers get a
//               two-cycle ERROR response and never touch the macro.
//   undefined - no checks; addresses wrap modulo MEM_BYTES and HRESP is 0.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   HSEL..HREADY        AHB-Lite slave inputs
//   HREADYOUT, HRESP    AHB-Lite slave response
//   HRDATA              read data (full word, zero outside read data phase)
//   sram_cs/we/be/addr/wdata   macro controls (gated by rst_n)
//   sram_rdata          macro read data, one cycle after a read cycle
module rv32_ahb_sram_slave #(
    parameter int MEM_BYTES = 65536,
    parameter int AW        = $clog2(MEM_BYTES / 4)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [3:0]    sram_be,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD       = 3'd2,
        RD_DEFER = 3'd3
`ifdef RV32_SRAM_ERRCHK_EN
        ,
        ERR1     = 3'd4,
        ERR2     = 3'd5
`endif
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [AW-1:0] addr_r;
    logic [3:0]    be_r;
    logic [3:0]    be_s;
    logic          stall_s;
    logic          accept_s;
    logic          err_s;
    logic          rd_now_s;
    logic          unused_s;

    // Our own wait-state cycles never accept a new transfer.
`ifdef RV32_SRAM_ERRCHK_EN
    assign stall_s = (state_r == RD_DEFER) || (state_r == ERR1);
`else
    assign stall_s = (state_r == RD_DEFER);
`endif

    assign accept_s = HSEL & HREADY & HTRANS[1] & ~stall_s;

`ifdef RV32_SRAM_ERRCHK_EN
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
    assign err_s = ({1'b0, HADDR} >= MEM_LIMIT)
                 | (HSIZE > 3'd2)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    assign unused_s = HTRANS[0];
`else
    assign err_s    = 1'b0;
    assign unused_s = ^{HTRANS[0], HADDR[31:AW+2]};
`endif

    // A read can use the macro immediately unless a write data phase owns it.
    assign rd_now_s = accept_s & ~HWRITE & ~err_s & (state_r != WR);

    // Address-phase byte-lane enables.
    always_comb begin
        be_s = 4'b0000;
        case (HSIZE)
            3'd0:    be_s = 4'b0001 << HADDR[1:0];
            3'd1:    be_s = HADDR[1] ? 4'b1100 : 4'b0011;
            default: be_s = 4'b1111;
        endcase
    end

    // State register plus the address/lanes kept for the data phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            addr_r  <= '0;
            be_r    <= 4'b0000;
        end else begin
            state_r <= state_s;
            if (accept_s && !err_s) begin
                addr_r <= HADDR[AW+1:2];
                be_r   <= be_s;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = IDLE;
        if (accept_s) begin
`ifdef RV32_SRAM_ERRCHK_EN
            if (err_s) state_s = ERR1;
            else
`endif
            if (HWRITE)              state_s = WR;
            else if (state_r == WR)  state_s = RD_DEFER;
            else                     state_s = RD;
        end else begin
            case (state_r)
                RD_DEFER: state_s = RD;
`ifdef RV32_SRAM_ERRCHK_EN
                ERR1:     state_s = ERR2;
`endif
                default:  state_s = IDLE;
            endcase
        end
    end

    // Bus response and macro controls; everything idles while rst_n is low
    // so a write caught mid data phase is never issued.
    always_comb begin
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        HRDATA     = 32'h0000_0000;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = 32'h0000_0000;
        if (!rst_n) begin
            HREADYOUT = 1'b1;
        end else begin
            case (state_r)
                WR: begin
                    sram_cs    = 1'b1;
                    sram_we    = 1'b1;
                    sram_be    = be_r;
                    sram_addr  = addr_r;
                    sram_wdata = HWDATA;
                end
                RD_DEFER: begin
                    HREADYOUT = 1'b0;
                    sram_cs   = 1'b1;
                    sram_be   = be_r;
                    sram_addr = addr_r;
                end
                RD: HRDATA = sram_rdata;
`ifdef RV32_SRAM_ERRCHK_EN
                ERR1: begin
                    HREADYOUT = 1'b0;
                    HRESP     = 1'b1;
                end
                ERR2: HRESP = 1'b1;
`endif
                default: HREADYOUT = 1'b1;
            endcase
            // WR never overlaps this: a read arriving in WR is deferred.
            if (rd_now_s) begin
                sram_cs   = 1'b1;
                sram_we   = 1'b0;
                sram_be   = be_s;
                sram_addr = HADDR[AW+1:2];
            end else begin
                sram_cs = sram_cs;
            end
        end
    end

endmodule

// File: tb/tb_rv32_ahb_sram_slave.sv
// Self-checking bench for rv32_ahb_sram_slave: directed scenarios plus a
// randomized pipelined transfer stream, checked against a byte-array model.
module tb_rv32_ahb_sram_slave;

    localparam int MEM_BYTES = 65536;
    localparam int AW        = 14;
    localparam int QN        = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic          sram_cs;
    logic          sram_we;
    logic [3:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata = 32'h0;
    logic          other_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;

    // transfer queue and observations
    logic        q_wr    [QN];
    logic [31:0] q_addr  [QN];
    logic [2:0]  q_size  [QN];
    logic [31:0] q_wdata [QN];
    logic [31:0] obs_rdata [QN];
    logic        obs_resp  [QN];
    logic [3:0]  obs_be    [QN];
    int          obs_waits [QN];

    logic [7:0]  ref_mem  [MEM_BYTES];
    logic [31:0] sram_mem [MEM_BYTES/4];
    bit          mem_loaded = 1'b0;

    assign HREADY = HREADYOUT & other_ready;

    rv32_ahb_sram_slave #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
    endfunction

    // SRAM macro model
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < MEM_BYTES/4; i++) sram_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (sram_cs === 1'b1) begin
            if (sram_we === 1'b1) begin
                for (int l = 0; l < 4; l++)
                    if (sram_be[l]) sram_mem[sram_addr][8*l +: 8] <= sram_wdata[8*l +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    always @(negedge clk) if (sram_cs === 1'b1 && sram_we === 1'b1) we_cnt <= we_cnt + 1;

    // ---------------- reference model ----------------
    function automatic bit lane_en(input logic [2:0] sz, input logic [31:0] a, input int lane);
        if (sz == 3'd0)      return lane == int'(a % 4);
        else if (sz == 3'd1) return (lane / 2) == int'((a / 2) % 2);
        else                 return 1'b1;
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
`ifdef RV32_SRAM_ERRCHK_EN
        return (a >= 32'(MEM_BYTES)) || (sz > 3'd2) ||
               (sz == 3'd1 && (a % 2) != 0) || (sz == 3'd2 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int base_of(input logic [31:0] a);
        return int'((a % 32'(MEM_BYTES)) / 4 * 4);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = base_of(a);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HADDR = 32'h0; HSIZE = 3'd0; HWDATA = 32'h0;
    endtask

    // Drive n queued transfers back to back, pipelined like an AHB master.
    task automatic run_seq(input int n);
        int a, d, cyc;
        bit dv, hr;
        a = 0; d = 0; dv = 1'b0; cyc = 0;
        for (int k = 0; k < n; k++) begin
            obs_waits[k] = 0; obs_rdata[k] = 32'hX; obs_resp[k] = 1'bX; obs_be[k] = 4'h0;
        end
        while ((a < n || dv) && cyc < 400) begin
            if (a < n) begin
                HSEL = 1'b1; HTRANS = 2'b10; HWRITE = q_wr[a];
                HADDR = q_addr[a]; HSIZE = q_size[a];
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HSIZE = 3'd0;
            end
            HWDATA = (dv && q_wr[d]) ? q_wdata[d] : 32'h0;
            #1;
            if (dv) begin
                if (q_wr[d] && sram_cs === 1'b1 && sram_we === 1'b1) obs_be[d] = sram_be;
                if (HREADYOUT === 1'b1) begin
                    obs_rdata[d] = HRDATA;
                    obs_resp[d]  = HRESP;
                end else begin
                    obs_waits[d]++;
                end
            end
            hr = (HREADY === 1'b1);
            step();
            cyc++;
            if (hr) begin
                dv = (a < n);
                d  = a;
                if (a < n) a++;
            end
        end
        n_tests++;
        assert (cyc < 400) else begin
            n_fail++;
            $error("FAIL seq_timeout: got %0d cycles, expected < 400", cyc);
        end
        bus_idle();
        step();
    endtask

    // Compare the observations of a sequence against the model, in order.
    task automatic check_seq(input int n, input string tag);
        bit prev_wr;
        prev_wr = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (is_err(q_addr[k], q_size[k])) begin
                chk($sformatf("%s[%0d].resp", tag, k), 32'(obs_resp[k]), 32'd1);
                chk($sformatf("%s[%0d].waits", tag, k), 32'(obs_waits[k]), 32'd1);
                prev_wr = 1'b0;
            end else if (q_wr[k]) begin
                logic [3:0] eb;
                int b;
                eb = 4'h0;
                b  = base_of(q_addr[k]);
                for (int l = 0; l < 4; l++)
                    if (lane_en(q_size[k], q_addr[k], l)) begin
                        eb[l] = 1'b1;
                        ref_mem[b+l] = q_wdata[k][8*l +: 8];
                    end
                chk($sformatf("%s[%0d].be", tag, k), 32'(obs_be[k]), 32'(eb));
                chk($sformatf("%s[%0d].waits", tag, k), 32'(obs_waits[k]), 32'd0);
                chk($sformatf("%s[%0d].resp", tag, k), 32'(obs_resp[k]), 32'd0);
                prev_wr = 1'b1;
            end else begin
                chk($sformatf("%s[%0d].rdata", tag, k), obs_rdata[k], ref_word(q_addr[k]));
                chk($sformatf("%s[%0d].waits", tag, k), 32'(obs_waits[k]), prev_wr ? 32'd1 : 32'd0);
                chk($sformatf("%s[%0d].resp", tag, k), 32'(obs_resp[k]), 32'd0);
                prev_wr = 1'b0;
            end
        end
    endtask

    task automatic put(input int k, input logic wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd);
        q_wr[k] = wr; q_addr[k] = a; q_size[k] = sz; q_wdata[k] = wd;
    endtask

    initial begin
        logic [7:0] orig_b2;
        int we_before;
        for (int i = 0; i < MEM_BYTES/4; i++)
            for (int l = 0; l < 4; l++) ref_mem[4*i+l] = init_word(i)[8*l +: 8];
        rst_n = 1'b0;
        other_ready = 1'b1;
        bus_idle();

        // reset
        step(); step();
        chk("rst.hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst.hresp", 32'(HRESP), 32'd0);
        chk("rst.hrdata", HRDATA, 32'h0);
        chk("rst.cs", {29'd0, sram_cs, sram_we, 1'b0} | 32'(sram_be), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("idle.hreadyout", 32'(HREADYOUT), 32'd1);
            chk("idle.hresp", 32'(HRESP), 32'd0);
            chk("idle.hrdata", HRDATA, 32'h0);
            chk("idle.cs", 32'(sram_cs), 32'd0);
        end

        // word write then deferred read, then zero-wait read
        put(0, 1'b1, 32'h100, 3'd2, 32'hDEAD_BEEF);
        put(1, 1'b0, 32'h100, 3'd2, 32'h0);
        put(2, 1'b0, 32'h104, 3'd2, 32'h0);
        run_seq(3);
        chk("raw.data", obs_rdata[1], 32'hDEAD_BEEF);
        chk("raw.waits", 32'(obs_waits[1]), 32'd1);
        chk("rd2.waits", 32'(obs_waits[2]), 32'd0);
        check_seq(3, "wr_rd");

        // byte and half writes, then word read
        orig_b2 = ref_mem[32'h202];
        put(0, 1'b1, 32'h203, 3'd0, 32'hAA00_0000);
        put(1, 1'b1, 32'h200, 3'd1, 32'h0000_1234);
        put(2, 1'b0, 32'h200, 3'd2, 32'h0);
        run_seq(3);
        chk("byte.be", 32'(obs_be[0]), 32'h8);
        chk("half.be", 32'(obs_be[1]), 32'h3);
        chk("mix.data", obs_rdata[2], {8'hAA, orig_b2, 16'h1234});
        check_seq(3, "narrow");

        // stalled bus: another slave holds HREADY low
        other_ready = 1'b0;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h300; HSIZE = 3'd2;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall.cs", 32'(sram_cs), 32'd0);
            step();
        end
        other_ready = 1'b1;
        #1;
        chk("stall.go_cs", 32'(sram_cs), 32'd1);
        chk("stall.addr", 32'(sram_addr), 32'h300 >> 2);
        step();
        bus_idle();
        #1;
        chk("stall.rdata", HRDATA, ref_word(32'h300));
        step();

`ifdef RV32_SRAM_ERRCHK_EN
        // out-of-range read: two-cycle error, no macro access
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'(MEM_BYTES); HSIZE = 3'd2;
        #1;
        chk("err.addr_cs", 32'(sram_cs), 32'd0);
        step();
        bus_idle();
        #1;
        chk("err1.hready", 32'(HREADYOUT), 32'd0);
        chk("err1.hresp", 32'(HRESP), 32'd1);
        chk("err1.cs", 32'(sram_cs), 32'd0);
        step();
        #1;
        chk("err2.hready", 32'(HREADYOUT), 32'd1);
        chk("err2.hresp", 32'(HRESP), 32'd1);
        step();
        put(0, 1'b0, 32'h102, 3'd2, 32'h0);
        put(1, 1'b0, 32'h100, 3'd2, 32'h0);
        run_seq(2);
        check_seq(2, "misalign");
`else
        // addresses wrap modulo the memory size
        put(0, 1'b0, 32'(MEM_BYTES) + 32'h100, 3'd2, 32'h0);
        run_seq(1);
        chk("wrap.data", obs_rdata[0], 32'hDEAD_BEEF);
        check_seq(1, "wrap");
`endif

        // reset during a write data phase drops the write
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h400; HSIZE = 3'd2;
        step();
        bus_idle();
        HWDATA = 32'h0BAD_F00D;
        rst_n = 1'b0;
        #1;
        chk("mrst.we", 32'(sram_we), 32'd0);
        we_before = we_cnt;
        step(); step();
        rst_n = 1'b1;
        step(); step();
        chk("mrst.we_cnt", 32'(we_cnt), 32'(we_before));
        put(0, 1'b0, 32'h400, 3'd2, 32'h0);
        run_seq(1);
        chk("mrst.old", obs_rdata[0], init_word(32'h400 / 4));
        check_seq(1, "mrst");

        // randomized pipelined stream in a small window to provoke RAW
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  sz;
            logic [31:0] a;
            sz = 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 31) * 4);
            if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
            else if (sz == 3'd1) a = a + 32'($urandom_range(0, 1) * 2);
            else a = a;
            put(k, 1'($urandom_range(0, 1)), a, sz, $urandom);
        end
        run_seq(40);
        check_seq(40, "rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
